// File: rtl/riscv_mt_register_file_ctx.sv
// Multi-hart integer register file: 3 combinational read ports, 2 write ports,
// optional write-to-read bypass and a sequential per-hart context-clear engine.
module riscv_mt_register_file_ctx #(
  parameter  int ADDR_WIDTH   = 5,
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_HARTS    = 4,
  parameter  int WRITE_BYPASS = 1,
  localparam int HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HART_W-1:0]     hart_id_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  input  logic [HART_W-1:0]     hart_id_wb_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic                  we_a_i,
  input  logic [HART_W-1:0]     hart_id_ex_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  we_b_i,
  input  logic                  clr_req_i,
  input  logic [HART_W-1:0]     clr_hart_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic                  wr_drop_o
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  clr_state_e              state_q, state_d;
  logic [HART_W-1:0]       clr_hart_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    clr_start;

  logic [DATA_WIDTH-1:0]   mem [NUM_HARTS][NUM_WORDS];

  logic                    a_hart_ok, b_hart_ok, rd_hart_ok, clr_hart_ok;
  logic                    a_drop, b_drop, a_ok, b_ok;
  logic [ADDR_WIDTH-1:0]   raddr [3];
  logic [DATA_WIDTH-1:0]   rdata [3];

  assign a_hart_ok   = 32'(hart_id_wb_i) < NUM_HARTS;
  assign b_hart_ok   = 32'(hart_id_ex_i) < NUM_HARTS;
  assign rd_hart_ok  = 32'(hart_id_i)    < NUM_HARTS;
  assign clr_hart_ok = 32'(clr_hart_i)   < NUM_HARTS;

  // A write is dropped when its hart does not exist or is the one being cleared.
  assign a_drop = we_a_i && (!a_hart_ok || (clr_busy_o && (hart_id_wb_i == clr_hart_q)));
  assign b_drop = we_b_i && (!b_hart_ok || (clr_busy_o && (hart_id_ex_i == clr_hart_q)));
  assign a_ok   = we_a_i && (waddr_a_i != '0) && !a_drop;
  assign b_ok   = we_b_i && (waddr_b_i != '0) && !b_drop;
  assign wr_drop_o = !rst && (a_drop || b_drop);

  always_comb begin
    state_d    = state_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    clr_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req_i && clr_hart_ok) begin
          state_d   = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy_o = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_hart_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      if (clr_start) begin
        clr_hart_q <= clr_hart_i;
        idx_q      <= '0;
      end else if (clr_busy_o) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Port A is applied last so it wins when both ports hit the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
          mem[HART_W'(h)][ADDR_WIDTH'(w)] <= '0;
        end
      end
    end else begin
      if (clr_busy_o) mem[clr_hart_q][idx_q] <= '0;
      if (b_ok) mem[hart_id_ex_i][waddr_b_i - 1'b1] <= wdata_b_i;
      if (a_ok) mem[hart_id_wb_i][waddr_a_i - 1'b1] <= wdata_a_i;
    end
  end

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;
  assign raddr[2] = raddr_c_i;

  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rdata[2'(p)] = '0;
      if ((raddr[2'(p)] != '0) && rd_hart_ok) begin
        rdata[2'(p)] = mem[hart_id_i][raddr[2'(p)] - 1'b1];
        if (WRITE_BYPASS != 0) begin
          if (b_ok && (hart_id_ex_i == hart_id_i) && (waddr_b_i == raddr[2'(p)]))
            rdata[2'(p)] = wdata_b_i;
          if (a_ok && (hart_id_wb_i == hart_id_i) && (waddr_a_i == raddr[2'(p)]))
            rdata[2'(p)] = wdata_a_i;
        end
      end
    end
  end

  assign rdata_a_o = rdata[0];
  assign rdata_b_o = rdata[1];
  assign rdata_c_o = rdata[2];

endmodule

// File: tb/tb_riscv_mt_register_file_ctx.sv
// Directed bench: a 4-hart bypassing instance and a 3-hart non-bypassing
// instance share all inputs so out-of-range harts can be compared side by side.
module tb_riscv_mt_register_file_ctx;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int HW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [HW-1:0] hart_id, hart_wb, hart_ex, clr_hart;
  logic [AW-1:0] ra, rb, rc, wa_a, wa_b;
  logic [DW-1:0] wd_a, wd_b;
  logic          we_a, we_b, clr_req;

  logic [DW-1:0] rd_a4, rd_b4, rd_c4, rd_a3, rd_b3, rd_c3;
  logic          busy4, done4, drop4, busy3, done3, drop3;

  int errors = 0;
  int checks = 0;

  riscv_mt_register_file_ctx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_HARTS(4), .WRITE_BYPASS(1)) dut4 (
    .clk(clk), .rst(rst), .hart_id_i(hart_id),
    .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc),
    .rdata_a_o(rd_a4), .rdata_b_o(rd_b4), .rdata_c_o(rd_c4),
    .hart_id_wb_i(hart_wb), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .we_a_i(we_a),
    .hart_id_ex_i(hart_ex), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .we_b_i(we_b),
    .clr_req_i(clr_req), .clr_hart_i(clr_hart),
    .clr_busy_o(busy4), .clr_done_o(done4), .wr_drop_o(drop4)
  );

  riscv_mt_register_file_ctx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_HARTS(3), .WRITE_BYPASS(0)) dut3 (
    .clk(clk), .rst(rst), .hart_id_i(hart_id),
    .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc),
    .rdata_a_o(rd_a3), .rdata_b_o(rd_b3), .rdata_c_o(rd_c3),
    .hart_id_wb_i(hart_wb), .waddr_a_i(wa_a), .wdata_a_i(wd_a), .we_a_i(we_a),
    .hart_id_ex_i(hart_ex), .waddr_b_i(wa_b), .wdata_b_i(wd_b), .we_b_i(we_b),
    .clr_req_i(clr_req), .clr_hart_i(clr_hart),
    .clr_busy_o(busy3), .clr_done_o(done3), .wr_drop_o(drop3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we_a = 1'b0;
    we_b = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in();
    hart_id = '0; hart_wb = '0; hart_ex = '0; clr_hart = '0;
    ra = 5'd5; rb = 5'd31; rc = 5'd0;
    wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0;
    tick(); tick();
    rst = 1'b0; #1;
    checks++; if ({busy4, done4, drop4, busy3, done3, drop3} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000000", {busy4, done4, drop4, busy3, done3, drop3});
    end
    checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL reset_h0_x5 got=%h exp=0", rd_a4); end
    hart_id = 2'd2; #1;
    checks++; if (rd_b4 !== 32'h0) begin errors++; $display("FAIL reset_h2_x31 got=%h exp=0", rd_b4); end
    checks++; if (rd_b3 !== 32'h0) begin errors++; $display("FAIL reset3_h2_x31 got=%h exp=0", rd_b3); end
  endtask

  task automatic test_basic();
    we_a = 1'b1; hart_wb = 2'd0; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
    we_b = 1'b1; hart_ex = 2'd1; wa_b = 5'd5; wd_b = 32'h12345678;
    tick(); idle_in();
    hart_id = 2'd0; ra = 5'd5; rb = 5'd0; rc = 5'd5; #1;
    checks++; if (rd_a4 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_h0_x5 got=%h exp=deadbeef", rd_a4); end
    checks++; if (rd_b4 !== 32'h0) begin errors++; $display("FAIL basic_x0 got=%h exp=0", rd_b4); end
    checks++; if (rd_c4 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_portc got=%h exp=deadbeef", rd_c4); end
    hart_id = 2'd1; #1;
    checks++; if (rd_a4 !== 32'h12345678) begin errors++; $display("FAIL basic_h1_x5 got=%h exp=12345678", rd_a4); end
    checks++; if (rd_a3 !== 32'h12345678) begin errors++; $display("FAIL basic3_h1_x5 got=%h exp=12345678", rd_a3); end
  endtask

  task automatic test_same_addr();
    we_a = 1'b1; hart_wb = 2'd2; wa_a = 5'd7; wd_a = 32'h1;
    we_b = 1'b1; hart_ex = 2'd2; wa_b = 5'd7; wd_b = 32'h2;
    hart_id = 2'd2; ra = 5'd7; #1;
    checks++; if (rd_a4 !== 32'h1) begin errors++; $display("FAIL bypass_a_wins got=%h exp=1", rd_a4); end
    checks++; if (rd_a3 !== 32'h0) begin errors++; $display("FAIL nobypass_old got=%h exp=0", rd_a3); end
    tick(); idle_in(); #1;
    checks++; if (rd_a4 !== 32'h1) begin errors++; $display("FAIL same_addr_store got=%h exp=1", rd_a4); end
    checks++; if (rd_a3 !== 32'h1) begin errors++; $display("FAIL same_addr_store3 got=%h exp=1", rd_a3); end
    we_b = 1'b1; hart_ex = 2'd2; wa_b = 5'd8; wd_b = 32'h55; rb = 5'd8; #1;
    checks++; if (rd_b4 !== 32'h55) begin errors++; $display("FAIL bypass_b got=%h exp=55", rd_b4); end
    checks++; if (rd_b3 !== 32'h0) begin errors++; $display("FAIL nobypass_b got=%h exp=0", rd_b3); end
    tick(); idle_in(); #1;
    checks++; if (rd_b3 !== 32'h55) begin errors++; $display("FAIL store_b3 got=%h exp=55", rd_b3); end
  endtask

  task automatic test_clear();
    int nbusy4, ndone4, nbusy3, done_at;
    for (int i = 1; i <= 31; i++) begin
      we_a = 1'b1; hart_wb = 2'd3; wa_a = AW'(i); wd_a = DW'(i);
      tick();
    end
    idle_in();
    hart_id = 2'd3; ra = 5'd17; #1;
    checks++; if (rd_a4 !== 32'd17) begin errors++; $display("FAIL fill_h3_x17 got=%h exp=11", rd_a4); end
    ra = 5'd10; rb = 5'd11; rc = 5'd31;
    clr_req = 1'b1; clr_hart = 2'd3;
    tick(); clr_req = 1'b0;
    nbusy4 = 0; ndone4 = 0; nbusy3 = 0; done_at = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (busy4) nbusy4++;
      if (done4) begin ndone4++; done_at = cyc; end
      if (busy3) nbusy3++;
      if (cyc == 10) begin
        checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL partial_x10 got=%h exp=0", rd_a4); end
        checks++; if (rd_b4 !== 32'd11) begin errors++; $display("FAIL partial_x11 got=%h exp=b", rd_b4); end
      end
      tick();
    end
    checks++; if (nbusy4 !== 31) begin errors++; $display("FAIL clr_busy_cycles got=%0d exp=31", nbusy4); end
    checks++; if (ndone4 !== 1) begin errors++; $display("FAIL clr_done_pulses got=%0d exp=1", ndone4); end
    checks++; if (done_at !== 31) begin errors++; $display("FAIL clr_done_cycle got=%0d exp=31", done_at); end
    checks++; if (nbusy3 !== 0) begin errors++; $display("FAIL oob_clr_ignored got=%0d exp=0", nbusy3); end
    ra = 5'd1; rb = 5'd17; rc = 5'd31; #1;
    checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL cleared_x1 got=%h exp=0", rd_a4); end
    checks++; if (rd_b4 !== 32'h0) begin errors++; $display("FAIL cleared_x17 got=%h exp=0", rd_b4); end
    checks++; if (rd_c4 !== 32'h0) begin errors++; $display("FAIL cleared_x31 got=%h exp=0", rd_c4); end
    hart_id = 2'd0; ra = 5'd5; #1;
    checks++; if (rd_a4 !== 32'hDEADBEEF) begin errors++; $display("FAIL h0_kept got=%h exp=deadbeef", rd_a4); end
  endtask

  task automatic test_clear_collision();
    int nbusy, ndone;
    we_a = 1'b1; hart_wb = 2'd1; wa_a = 5'd4; wd_a = 32'h77;
    tick(); idle_in();
    clr_req = 1'b1; clr_hart = 2'd1;
    tick();
    nbusy = 0; ndone = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      idle_in();
      if (cyc == 3) begin
        we_a = 1'b1; hart_wb = 2'd1; wa_a = 5'd4; wd_a = 32'hAA;
        we_b = 1'b1; hart_ex = 2'd0; wa_b = 5'd4; wd_b = 32'hBB;
        hart_id = 2'd1; ra = 5'd4;
      end
      if (cyc == 6) begin clr_req = 1'b1; clr_hart = 2'd2; end
      #1;
      if (busy4) nbusy++;
      if (done4) ndone++;
      if (cyc == 3) begin
        checks++; if (drop4 !== 1'b1) begin errors++; $display("FAIL clr_drop got=%b exp=1", drop4); end
        checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL clr_drop3 got=%b exp=1", drop3); end
        checks++; if (rd_a4 !== 32'h77) begin errors++; $display("FAIL dropped_no_bypass got=%h exp=77", rd_a4); end
      end
      tick();
    end
    hart_id = 2'd1; ra = 5'd4; #1;
    checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL h1_x4_cleared got=%h exp=0", rd_a4); end
    hart_id = 2'd0; #1;
    checks++; if (rd_a4 !== 32'hBB) begin errors++; $display("FAIL h0_x4_written got=%h exp=bb", rd_a4); end
    checks++; if (nbusy !== 31) begin errors++; $display("FAIL coll_busy_cycles got=%0d exp=31", nbusy); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL coll_done_pulses got=%0d exp=1", ndone); end
  endtask

  task automatic test_oob();
    we_a = 1'b1; hart_wb = 2'd3; wa_a = 5'd9; wd_a = 32'h99; #1;
    checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL oob_drop3 got=%b exp=1", drop3); end
    checks++; if (drop4 !== 1'b0) begin errors++; $display("FAIL oob_drop4 got=%b exp=0", drop4); end
    tick(); idle_in();
    hart_id = 2'd3; ra = 5'd9; #1;
    checks++; if (rd_a3 !== 32'h0) begin errors++; $display("FAIL oob_read3 got=%h exp=0", rd_a3); end
    checks++; if (rd_a4 !== 32'h99) begin errors++; $display("FAIL h3_read4 got=%h exp=99", rd_a4); end
    hart_id = 2'd1; #1;
    checks++; if (rd_a3 !== 32'h0) begin errors++; $display("FAIL oob_no_alias got=%h exp=0", rd_a3); end
    we_a = 1'b1; hart_wb = 2'd0; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
    hart_id = 2'd0; ra = 5'd0; rb = 5'd31; #1;
    checks++; if (drop4 !== 1'b0) begin errors++; $display("FAIL x0_write_drop got=%b exp=0", drop4); end
    checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd_a4); end
    tick(); idle_in(); #1;
    checks++; if (rd_b4 !== 32'h0) begin errors++; $display("FAIL x0_write_wrap got=%h exp=0", rd_b4); end
  endtask

  task automatic test_reset_mid_clear();
    int nbusy, ndone;
    clr_req = 1'b1; clr_hart = 2'd2;
    tick(); clr_req = 1'b0;
    nbusy = 0; ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rst = (cyc == 10);
      #1;
      if (busy4) nbusy++;
      if (done4) ndone++;
      if (cyc == 11) begin
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy_drop got=%b exp=0", busy4); end
      end
      tick();
    end
    rst = 1'b0;
    checks++; if (nbusy !== 11) begin errors++; $display("FAIL rst_busy_cycles got=%0d exp=11", nbusy); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", ndone); end
    hart_id = 2'd0; ra = 5'd5; rb = 5'd4; #1;
    checks++; if (rd_a4 !== 32'h0) begin errors++; $display("FAIL rst_h0_x5 got=%h exp=0", rd_a4); end
    checks++; if (rd_b4 !== 32'h0) begin errors++; $display("FAIL rst_h0_x4 got=%h exp=0", rd_b4); end
    hart_id = 2'd1; #1;
    checks++; if (rd_a3 !== 32'h0) begin errors++; $display("FAIL rst3_h1_x5 got=%h exp=0", rd_a3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_clear();
    test_clear_collision();
    test_oob();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
